// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB widths and slave FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_slave_ram.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_ram
// Description : Word storage, synchronous write, combinational read, cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_ram #(
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule : apb_slave_ram
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_mem
// Description : APB slave memory with programmable wait states and range checking.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int                    DEPTH       = 256,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  hresetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int         c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    apb_state_t            r_state;
    logic [3:0]            r_cnt;
    logic [APB_ADDR_W-1:0] r_addr;
    logic [APB_DATA_W-1:0] r_wdata;
    logic                  r_write;

    logic [APB_ADDR_W-1:0] w_idx;
    logic                  w_err;
    logic                  w_done;
    logic                  w_we;
    logic [APB_DATA_W-1:0] w_rdata;

    // Offset wraps for addresses below the base, so that case is caught by the range test too.
    assign w_idx   = (r_addr - BASE_ADDR) >> 2;
    assign w_err   = (r_addr[1:0] != 2'b00) || (r_addr < BASE_ADDR) || (w_idx >= 32'(DEPTH));
    assign pready  = (r_state == ACCESS) && (r_cnt == 4'd0);
    assign w_done  = pready && psel && penable;
    assign w_we    = w_done && r_write && !w_err;
    assign pslverr = pready && w_err;
    assign prdata  = (pready && !w_err && !r_write) ? w_rdata : '0;

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (psel && !penable) begin
                        r_addr  <= paddr;
                        r_wdata <= pwdata;
                        r_write <= pwrite;
                        r_cnt   <= c_WAIT;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_state <= psel ? ACCESS : IDLE;
                end
                ACCESS: begin
                    // penable low holds both state and count.
                    if (!psel) begin
                        r_state <= IDLE;
                    end else if (penable) begin
                        if (r_cnt == 4'd0) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    apb_slave_ram #(
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W),
        .DATA_W (APB_DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (hresetn),
        .i_we    (w_we),
        .i_idx   (w_idx[c_IDX_W-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

endmodule : apb_slave_mem
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_mem
// Description : Scoreboard bench for apb_slave_mem, WAIT_CYCLES=1 and WAIT_CYCLES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_mem;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        hresetn;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;
    int   rdy_seen [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .hresetn(hresetn), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );

    apb_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .hresetn(hresetn), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );

    // Monitor: every completing access is matched against the oldest pending expectation.
    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            exp_t e;
            bit   have;
            if (pready[b]) rdy_seen[b]++;
            if (hresetn && psel[b] && penable[b] && pready[b]) begin
                have = 1'b0;
                if (b == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end else if (b == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                n_vec++;
                if (!have) begin
                    n_mis++;
                    $display("FAIL unexpected_pready dut%0d: pready=1 at cycle %0d, required no pending transfer", b, cyc);
                end else if (prdata[b] !== e.rdata || pslverr[b] !== e.err || cyc != e.cyc) begin
                    n_mis++;
                    $display("FAIL xfer dut%0d: prdata=%h pslverr=%b cycle=%0d, required prdata=%h pslverr=%b cycle=%0d",
                             b, prdata[b], pslverr[b], cyc, e.rdata, e.err, e.cyc);
                end
            end
        end
    end

    function automatic int wait_of(input int b);
        return (b == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 of the bus setup cycle; returns at posedge+1 after the completion edge.
    task automatic xfer(input int b, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int stall, input bit keep);
        exp_t e;
        bit   done;
        psel[b]    = 1'b1;
        penable[b] = 1'b0;
        pwrite[b]  = wr;
        paddr[b]   = addr;
        pwdata[b]  = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + 2 + wait_of(b) + stall;
        if (b == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk) #1;
        penable[b] = 1'b1;
        repeat (stall) begin
            @(posedge clk) #1;
            penable[b] = 1'b0;
        end
        if (stall > 0) begin
            @(posedge clk) #1;
            penable[b] = 1'b1;
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (pready[b]) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_mis++;
            $display("FAIL timeout dut%0d addr=%h: pready=0 after 40 cycles, required pready=1", b, addr);
        end
        @(posedge clk) #1;
        if (!keep) begin
            psel[b]    = 1'b0;
            penable[b] = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        int a;
        rdy_seen[0] = 0;
        rdy_seen[1] = 0;
        for (int b = 0; b < 2; b++) begin
            psel[b] = 1'b0; penable[b] = 1'b0; pwrite[b] = 1'b0; paddr[b] = '0; pwdata[b] = '0;
        end
        hresetn = 1'b0;
        #3;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("reset_pready_dut%0d", b), 32'(pready[b]), 32'd0);
            chk($sformatf("reset_pslverr_dut%0d", b), 32'(pslverr[b]), 32'd0);
            chk($sformatf("reset_prdata_dut%0d", b), prdata[b], 32'd0);
        end
        #19;
        hresetn = 1'b1;
        @(posedge clk) #1;

        xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);

        // Abort a write to word 0 in its wait cycle.
        a = rdy_seen[0];
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h8000_0000; pwdata[0] = 32'hCAFE_F00D;
        @(posedge clk) #1;
        penable[0] = 1'b1;
        @(posedge clk) #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        repeat (3) @(posedge clk) #1;
        chk("abort_no_pready", 32'(rdy_seen[0] - a), 32'd0);
        xfer(0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 4; i++)
            xfer(0, 1'b1, 32'h8000_0000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 32'h0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++)
            xfer(0, 1'b0, 32'h8000_0000 + 32'(4 * i), 32'h0, 32'h1111_1111 * 32'(i + 1), 1'b0, 0, i < 3);

        xfer(0, 1'b1, 32'h8000_0400, 32'hBAD0_BAD0, 32'h0, 1'b1, 0, 1'b0);
        xfer(0, 1'b1, 32'h8000_0002, 32'hBAD1_BAD1, 32'h0, 1'b1, 0, 1'b0);
        xfer(0, 1'b1, 32'h7FFF_FFFC, 32'hBAD2_BAD2, 32'h0, 1'b1, 0, 1'b0);
        xfer(0, 1'b0, 32'h8000_0400, 32'h0, 32'h0, 1'b1, 0, 1'b0);
        xfer(0, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 1'b1, 0, 1'b0);
        xfer(0, 1'b0, 32'h8000_0000, 32'h0, 32'h1111_1111, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h8000_03FC, 32'h0, 32'h0, 1'b0, 0, 1'b0);

        xfer(0, 1'b1, 32'h8000_0044, 32'hA5A5_5A5A, 32'h0, 1'b0, 0, 1'b1);
        xfer(0, 1'b0, 32'h8000_0044, 32'h0, 32'hA5A5_5A5A, 1'b0, 0, 1'b0);

        // Access phase presented with no setup phase.
        a = rdy_seen[0];
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 32'h8000_0014; pwdata[0] = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk) #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk) #1;
        chk("idle_penable_ignored", 32'(rdy_seen[0] - a), 32'd0);
        xfer(0, 1'b0, 32'h8000_0014, 32'h0, 32'h0, 1'b0, 0, 1'b0);

        // Reset while a write sits in its completing access cycle.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h8000_0020; pwdata[0] = 32'h1234_5678;
        @(posedge clk) #1;
        penable[0] = 1'b1;
        @(posedge clk);
        @(posedge clk) #1;
        chk("pready_before_reset", 32'(pready[0]), 32'd1);
        hresetn = 1'b0;
        #1;
        chk("pready_in_reset", 32'(pready[0]), 32'd0);
        chk("pslverr_in_reset", 32'(pslverr[0]), 32'd0);
        chk("prdata_in_reset", prdata[0], 32'd0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        @(negedge clk) #1;
        hresetn = 1'b1;
        @(posedge clk) #1;
        xfer(0, 1'b0, 32'h8000_0020, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b0, 0, 1'b0);

        xfer(1, 1'b0, 32'h8000_0004, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        xfer(1, 1'b1, 32'h8000_0008, 32'h0BAD_CAFE, 32'h0, 1'b0, 2, 1'b1);
        xfer(1, 1'b0, 32'h8000_0008, 32'h0, 32'h0BAD_CAFE, 1'b0, 0, 1'b0);
        xfer(1, 1'b0, 32'h8000_0401, 32'h0, 32'h0, 1'b1, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue0_drained", 32'(q0.size()), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_apb_slave_mem
`default_nettype wire
